// File: rtl/pmcc_loop_stack.sv
// pmcc_loop_stack: hardware loop stack that holds nested loop contexts and decides, at each loop end, whether to jump back or retire the loop
module pmcc_loop_stack #(
  parameter int DEPTH = 10,
  parameter int ADDR_W = 10,
  parameter int ITER_W = 14,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic [ITER_W-1:0] push_iter_i,
  input  logic              pop_i,
  input  logic              loop_end_i,
  output logic [ADDR_W-1:0] top_addr_o,
  output logic [ITER_W-1:0] top_iter_o,
  output logic              loop_jump_o,
  output logic [ADDR_W-1:0] loop_jump_addr_o,
  output logic              loop_done_o,
  output logic [LVL_W-1:0]  level_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              err_overflow_o,
  output logic              err_underflow_o,
  output logic              err_illegal_o
);
  logic [ADDR_W-1:0] mem_addr_q [DEPTH];
  logic [ITER_W-1:0] mem_iter_q [DEPTH];
  logic [LVL_W-1:0]  level_q, level_d, top_idx, wr_idx;
  logic [ADDR_W-1:0] jaddr_q, jaddr_d;
  logic              jump_q, jump_d, done_q, done_d;
  logic              ovf_q, ovf_d, unf_q, unf_d, ill_q, ill_d;
  logic              wr, dec, run;
  assign run     = rst_n && !clear_i;
  assign top_idx = level_q - 1'b1;
  assign empty_o = level_q == '0;
  assign full_o  = level_q == LVL_W'(DEPTH);
  assign top_addr_o = empty_o ? '0 : mem_addr_q[top_idx];
  assign top_iter_o = empty_o ? '0 : mem_iter_q[top_idx];
  assign level_o = level_q;
  assign loop_jump_o = jump_q;
  assign loop_done_o = done_q;
  assign loop_jump_addr_o = jaddr_q;
  assign err_overflow_o = ovf_q;
  assign err_underflow_o = unf_q;
  assign err_illegal_o = ill_q;
  always_comb begin
    level_d = level_q;
    wr_idx = level_q;
    wr = 1'b0;
    dec = 1'b0;
    jump_d = 1'b0;
    done_d = 1'b0;
    jaddr_d = jaddr_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    ill_d = ill_q;
    if (loop_end_i && (push_i || pop_i)) ill_d = 1'b1;
    else if (push_i && (!pop_i || empty_o)) begin
      if (full_o) ovf_d = 1'b1;
      else begin
        wr = 1'b1;
        level_d = level_q + 1'b1;
      end
    end else if (push_i) begin
      wr = 1'b1;
      wr_idx = top_idx;
    end else if (pop_i) begin
      if (empty_o) unf_d = 1'b1;
      else level_d = top_idx;
    end else if (loop_end_i) begin
      if (empty_o) unf_d = 1'b1;
      else if (top_iter_o != '0) begin
        dec = 1'b1;
        jump_d = 1'b1;
        jaddr_d = top_addr_o;
      end else begin
        level_d = top_idx;
        done_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!run) begin
      level_q <= '0;
      jump_q <= 1'b0;
      done_q <= 1'b0;
      jaddr_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      level_q <= level_d;
      jump_q <= jump_d;
      done_q <= done_d;
      jaddr_q <= jaddr_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      ill_q <= ill_d;
    end
  end
  // entry storage is deliberately left unreset; level alone defines validity
  always_ff @(posedge clk) begin
    if (run && wr) begin
      mem_addr_q[wr_idx] <= push_addr_i;
      mem_iter_q[wr_idx] <= push_iter_i;
    end else if (run && dec) mem_iter_q[top_idx] <= top_iter_o - 1'b1;
  end
endmodule
